locked_register_bank: RTL

//  Bank of NUM_REGS lockable config registers; each has a sticky per-register lock bit plus a global lockdown.

---
 rtl/locked_reg_pkg.sv | 20 ++
 rtl/lock_key_fsm.sv | 53 +++++
 rtl/locked_register_bank.sv | 90 +++++++++
 3 files changed

// File: rtl/locked_reg_pkg.sv
// Shared types, default key words and helpers for the lockable register bank.
package locked_reg_pkg;

    typedef enum logic [1:0] {
        KS_OPEN,
        KS_ARMED,
        KS_LOCKED
    } key_state_t;

    localparam logic [15:0] KEY_A_DEFAULT = 16'hA5C3;
    localparam logic [15:0] KEY_B_DEFAULT = 16'h3C5A;

    // Saturating increment for a counter of 'width' bits (width < 32), carried in 32 bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (32'd1 << width) - 32'd1;
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/lock_key_fsm.sv
// Two-word key sequence that engages the terminal global lockdown.
module lock_key_fsm
    import locked_reg_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] KEY_A = WIDTH'(KEY_A_DEFAULT),
    parameter logic [WIDTH-1:0] KEY_B = WIDTH'(KEY_B_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic             write,
    input  logic [WIDTH-1:0] data_in,
    output logic             global_locked
);

    key_state_t state;
    key_state_t state_next;

    // NOTE: non-blocking assignment in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= KS_OPEN;
        end else begin
            state <= state_next;
        end
    end

    // A key word coinciding with a bus write is ignored.
    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        state_next = state;
        if (key_valid && !write) begin
            case (state)
                KS_OPEN: begin
                    if (data_in == KEY_A) state_next = KS_ARMED;
                end
                KS_ARMED: begin
                    if (data_in == KEY_B)      state_next = KS_LOCKED;
                    else if (data_in == KEY_A) state_next = KS_ARMED;
                    else                       state_next = KS_OPEN;
                end
                KS_LOCKED: state_next = KS_LOCKED;
                default:   state_next = KS_OPEN;
            endcase
        end
    end

    always_comb begin
        global_locked = (state == KS_LOCKED);
    end

endmodule

// File: rtl/locked_register_bank.sv
// Bank of lockable config registers with sticky per-register locks, global lockdown and violation tracking.
module locked_register_bank
    import locked_reg_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               NUM_REGS  = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] KEY_A     = WIDTH'(KEY_A_DEFAULT),
    parameter logic [WIDTH-1:0] KEY_B     = WIDTH'(KEY_B_DEFAULT),
    parameter int               CNT_W     = 8,
    localparam int              AW        = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      write,
    input  logic [AW-1:0]             addr,
    input  logic [WIDTH-1:0]          data_in,
    input  logic                      lock_set,
    input  logic                      key_valid,
    input  logic                      lock_override,
    input  logic [AW-1:0]             rd_addr,
    output logic [WIDTH-1:0]          rd_data,
    output logic [NUM_REGS*WIDTH-1:0] data_out,
    output logic [NUM_REGS-1:0]       lock_status,
    output logic                      global_locked,
    output logic                      violation,
    output logic [CNT_W-1:0]          violation_cnt
);

    localparam logic [AW:0] REG_COUNT = (AW + 1)'(NUM_REGS);

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic             addr_in_range;
    logic             rd_in_range;
    logic             write_allowed;
    logic [31:0]      cnt_next;

    lock_key_fsm #(
        .WIDTH (WIDTH),
        .KEY_A (KEY_A),
        .KEY_B (KEY_B)
    ) u_key_fsm (
        .clk           (clk),
        .reset         (reset),
        .key_valid     (key_valid),
        .write         (write),
        .data_in       (data_in),
        .global_locked (global_locked)
    );

    // Out-of-range targets are always dropped, even under override.
    always_comb begin
        addr_in_range = ({1'b0, addr} < REG_COUNT);
        rd_in_range   = ({1'b0, rd_addr} < REG_COUNT);
        write_allowed = addr_in_range &&
                        (lock_override || (!lock_status[addr] && !global_locked));
        cnt_next      = sat_inc(32'(violation_cnt), CNT_W);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the register array is reset because its contents feed security config directly.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
            lock_status   <= '0;
            violation     <= 1'b0;
            violation_cnt <= '0;
            rd_data       <= '0;
        end else begin
            violation <= 1'b0;
            if (write) begin
                if (write_allowed) begin
                    regs[addr] <= data_in;
                    if (lock_set) lock_status[addr] <= 1'b1;
                end else begin
                    violation     <= 1'b1;
                    violation_cnt <= cnt_next[CNT_W-1:0];
                end
            end
            // Reads see the pre-write contents when indexing the register being written.
            rd_data <= rd_in_range ? regs[rd_addr] : '0;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign data_out[i*WIDTH +: WIDTH] = regs[i];
    end

endmodule
